fpu_bus_master: RTL

- Hardware initiator for the FPU's 8-bit CPU-side register interface. It lets on-chip logic, such as a DMA or microsequencer, issue FPU operations without the CPU.
- Accepts one request (two 32-bit operands plus an operation code) on a valid/ready port.
- Performs the byte-serial bus writes (operand A, operand B, operation, start), waits for the FPU's cmd_end, reads back the 4 result bytes, and acknowledges with end_ack.
- Returns the 32-bit result on a valid/ready port.

---
 rtl/fpu_bus_master.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/fpu_bus_master.sv
// fpu_bus_master
// Hardware initiator for the FPU's byte-wide CPU-side register interface.
// Takes one request (operand A, operand B, operation code), writes the ten
// FPU registers (A bytes, B bytes, operation, start), waits for cmd_end,
// reads the four result bytes back, acknowledges with end_ack and returns
// the 32-bit result (or a timeout indication) on a valid/ready port.
//
// Ports:
//   clk, arst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready         request handshake
//   req_op_a/req_op_b           32-bit operands
//   req_operation               8-bit operation code
//   rsp_valid/rsp_ready         response handshake
//   rsp_result/rsp_timeout      32-bit result, timeout qualifier
//   fpu_addr/fpu_data_out       FPU register address and write data
//   fpu_data_in                 FPU read data
//   fpu_cs_n/fpu_rd_n/fpu_wr_n  active-low chip select and strobes
//   fpu_end_ack/fpu_cmd_end     command-end handshake with the FPU
//   busy                        high whenever not idle
module fpu_bus_master #(
    parameter int STROBE_CYCLES  = 1,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_op_a,
    input  logic [31:0] req_op_b,
    input  logic [7:0]  req_operation,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_timeout,
    output logic [3:0]  fpu_addr,
    output logic [7:0]  fpu_data_out,
    input  logic [7:0]  fpu_data_in,
    output logic        fpu_cs_n,
    output logic        fpu_rd_n,
    output logic        fpu_wr_n,
    output logic        fpu_end_ack,
    input  logic        fpu_cmd_end,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_WRITE, ST_WAIT_END, ST_READ, ST_ACK, ST_RESPOND
    } state_t;

    // Each access: SETUP -> STROBE -> HOLD, then GAP (cs_n high) before the next.
    typedef enum logic [1:0] {
        PH_SETUP, PH_STROBE, PH_HOLD, PH_GAP
    } phase_t;

    localparam logic [3:0]  STROBE_LAST = 4'(STROBE_CYCLES);
    localparam logic [15:0] TMO_LAST    = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  WR_LAST     = 4'd9;
    localparam logic [3:0]  RD_LAST     = 4'd3;
    localparam logic [3:0]  RD_BASE     = 4'd9;

    // Write data for access index: A bytes, B bytes, operation, then start (0).
    function automatic logic [7:0] wr_byte(input logic [3:0] idx, input logic [31:0] a,
                                           input logic [31:0] b, input logic [7:0] op);
        logic [7:0] r;
        case (idx)
            4'd0:    r = a[7:0];
            4'd1:    r = a[15:8];
            4'd2:    r = a[23:16];
            4'd3:    r = a[31:24];
            4'd4:    r = b[7:0];
            4'd5:    r = b[15:8];
            4'd6:    r = b[23:16];
            4'd7:    r = b[31:24];
            4'd8:    r = op;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    state_t      state_r;
    phase_t      phase_r;
    logic [3:0]  idx_r;
    logic [3:0]  strb_cnt_r;
    logic [15:0] tmo_cnt_r;
    logic [31:0] op_a_r;
    logic [31:0] op_b_r;
    logic [7:0]  oper_r;
    logic [31:0] result_r;
    logic [1:0]  cmd_sync_r;
    logic        cmd_end_s;
    logic [3:0]  next_idx_s;
    logic [3:0]  last_idx_s;
    logic [15:0] tmo_next_s;

    assign cmd_end_s  = cmd_sync_r[1];
    assign next_idx_s = idx_r + 4'd1;

    // Index of the final access of the current bus phase, and saturating timeout increment.
    always_comb begin
        last_idx_s = WR_LAST;
        if (state_r == ST_READ) begin
            last_idx_s = RD_LAST;
        end else begin
            last_idx_s = WR_LAST;
        end
        if (tmo_cnt_r == 16'hFFFF) begin
            tmo_next_s = tmo_cnt_r;
        end else begin
            tmo_next_s = tmo_cnt_r + 16'd1;
        end
    end

    // Two-flop synchronizer for the asynchronous cmd_end input.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cmd_sync_r <= 2'b00;
        end else begin
            cmd_sync_r <= {cmd_sync_r[0], fpu_cmd_end};
        end
    end

    // Transaction FSM; every bus and handshake output is a register of this block.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_r      <= ST_IDLE;
            phase_r      <= PH_SETUP;
            idx_r        <= 4'd0;
            strb_cnt_r   <= 4'd0;
            tmo_cnt_r    <= 16'd0;
            op_a_r       <= 32'd0;
            op_b_r       <= 32'd0;
            oper_r       <= 8'd0;
            result_r     <= 32'd0;
            req_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_result   <= 32'd0;
            rsp_timeout  <= 1'b0;
            fpu_addr     <= 4'd0;
            fpu_data_out <= 8'd0;
            fpu_cs_n     <= 1'b1;
            fpu_rd_n     <= 1'b1;
            fpu_wr_n     <= 1'b1;
            fpu_end_ack  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_a_r       <= req_op_a;
                        op_b_r       <= req_op_b;
                        oper_r       <= req_operation;
                        state_r      <= ST_WRITE;
                        phase_r      <= PH_SETUP;
                        idx_r        <= 4'd0;
                        fpu_cs_n     <= 1'b0;
                        fpu_addr     <= 4'd0;
                        fpu_data_out <= req_op_a[7:0];
                        req_ready    <= 1'b0;
                        busy         <= 1'b1;
                    end
                end
                ST_WRITE, ST_READ: begin
                    case (phase_r)
                        PH_SETUP: begin
                            phase_r    <= PH_STROBE;
                            strb_cnt_r <= 4'd1;
                            if (state_r == ST_WRITE) begin
                                fpu_wr_n <= 1'b0;
                            end else begin
                                fpu_rd_n <= 1'b0;
                            end
                        end
                        PH_STROBE: begin
                            if (strb_cnt_r == STROBE_LAST) begin
                                phase_r  <= PH_HOLD;
                                fpu_wr_n <= 1'b1;
                                fpu_rd_n <= 1'b1;
                                // Sampled on the edge that ends the strobe, rd_n still low.
                                if (state_r == ST_READ) begin
                                    result_r[{idx_r[1:0], 3'b000} +: 8] <= fpu_data_in;
                                end
                            end else begin
                                strb_cnt_r <= strb_cnt_r + 4'd1;
                            end
                        end
                        PH_HOLD: begin
                            fpu_cs_n <= 1'b1;
                            if (idx_r == last_idx_s) begin
                                tmo_cnt_r <= 16'd0;
                                if (state_r == ST_WRITE) begin
                                    state_r <= ST_WAIT_END;
                                end else begin
                                    state_r     <= ST_ACK;
                                    fpu_end_ack <= 1'b1;
                                end
                            end else begin
                                phase_r <= PH_GAP;
                            end
                        end
                        PH_GAP: begin
                            idx_r    <= next_idx_s;
                            phase_r  <= PH_SETUP;
                            fpu_cs_n <= 1'b0;
                            if (state_r == ST_WRITE) begin
                                fpu_addr     <= next_idx_s;
                                fpu_data_out <= wr_byte(next_idx_s, op_a_r, op_b_r, oper_r);
                            end else begin
                                fpu_addr <= RD_BASE + next_idx_s;
                            end
                        end
                        default: phase_r <= PH_SETUP;
                    endcase
                end
                ST_WAIT_END: begin
                    if (cmd_end_s) begin
                        state_r      <= ST_READ;
                        phase_r      <= PH_SETUP;
                        idx_r        <= 4'd0;
                        fpu_cs_n     <= 1'b0;
                        fpu_addr     <= RD_BASE;
                        fpu_data_out <= 8'd0;
                    end else if (tmo_cnt_r == TMO_LAST) begin
                        state_r     <= ST_RESPOND;
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_result  <= 32'd0;
                    end else begin
                        tmo_cnt_r <= tmo_next_s;
                    end
                end
                ST_ACK: begin
                    if (!cmd_end_s) begin
                        fpu_end_ack <= 1'b0;
                        state_r     <= ST_RESPOND;
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b0;
                        rsp_result  <= result_r;
                    end else if (tmo_cnt_r == TMO_LAST) begin
                        fpu_end_ack <= 1'b0;
                        state_r     <= ST_RESPOND;
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_result  <= 32'd0;
                    end else begin
                        tmo_cnt_r <= tmo_next_s;
                    end
                end
                ST_RESPOND: begin
                    if (rsp_ready) begin
                        rsp_valid   <= 1'b0;
                        rsp_timeout <= 1'b0;
                        state_r     <= ST_IDLE;
                        req_ready   <= 1'b1;
                        busy        <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
